// File: rtl/spi_bus_pkg.sv
// Shared constants and status helpers for byte-stream ports on the SPI gateway bus.
// Status bit positions are fixed so host firmware can decode any port's status byte.
package spi_bus_pkg;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_RX_OVF   = 4;

    // A status write with this bit set clears the sticky RX overflow.
    localparam int OVF_CLR_BIT = 7;

    localparam logic [7:0] FILL_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_DATA,
        ACC_STAT
    } access_e;

    typedef struct packed {
        logic ovf;
        logic rx_full;
        logic rx_empty;
        logic tx_full;
        logic tx_empty;
    } port_status_t;

    function automatic logic [7:0] pack_status(input port_status_t s);
        logic [7:0] b;
        b              = '0;
        b[ST_TX_EMPTY] = s.tx_empty;
        b[ST_TX_FULL]  = s.tx_full;
        b[ST_RX_EMPTY] = s.rx_empty;
        b[ST_RX_FULL]  = s.rx_full;
        b[ST_RX_OVF]   = s.ovf;
        return b;
    endfunction

endpackage

// File: rtl/spi_fifo_port_if.sv
// Host-side strobes of the SPI gateway internal bus, as seen by a port.
// The gate drives everything here; TXD returns on a separate tri-stated line.
interface spi_fifo_port_if;
    logic [7:0] RXD;
    logic [7:0] ADDR;
    logic       SEL;
    logic       TXE;
    logic       RXE;

    modport master (output RXD, ADDR, SEL, TXE, RXE);
    modport slave  (input  RXD, ADDR, SEL, TXE, RXE);
endinterface

// File: rtl/spi_fifo_port_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty/count.
// Overflowing pushes and underflowing pops are ignored, never corrupting state.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic [DEPTH_LOG2:0]   cnt_nxt;
    logic                  push_ok;
    logic                  pop_ok;

    // Acceptance is judged on the flags held at the start of the cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        cnt_nxt = cnt;
        if (push_ok && !pop_ok)
            cnt_nxt = cnt + 1'b1;
        else if (pop_ok && !push_ok)
            cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == CNT_FULL);
            empty <= (cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

endmodule

// File: rtl/spi_fifo_port.sv
// Multi-byte SPI gateway port: TX FIFO feeds the host, RX FIFO collects host bytes,
// and a second address exposes status / overflow clear.
module spi_fifo_port
    import spi_bus_pkg::*;
#(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] FILL       = FILL_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0]          ADDRESS,
    input  logic [7:0]          STAT_ADDRESS,
    spi_fifo_port_if.slave      bus,
    output logic [7:0]          TXD,
    input  logic                TX_WR,
    input  logic [7:0]          TX_DATA,
    output logic                TX_FULL,
    output logic [DEPTH_LOG2:0] TX_COUNT,
    input  logic                RX_RD,
    output logic [7:0]          RX_DATA,
    output logic                RX_EMPTY,
    output logic [DEPTH_LOG2:0] RX_COUNT,
    output logic                RX_OVF
);

    access_e    acc;
    logic       txe_q;
    logic       txe_rise;
    logic [7:0] hold;
    logic       hold_valid;
    logic [7:0] tx_head;
    logic       tx_empty;
    logic       rx_full;
    logic       data_commit;
    logic       stat_commit;
    logic       tx_pop;
    logic [7:0] status_byte;

    // Data address wins if both addresses are configured identically.
    always_comb begin
        acc = ACC_NONE;
        if (bus.SEL) begin
            if (bus.ADDR == ADDRESS)
                acc = ACC_DATA;
            else if (bus.ADDR == STAT_ADDRESS)
                acc = ACC_STAT;
        end
    end

    assign txe_rise    = bus.TXE && !txe_q;
    assign data_commit = bus.RXE && (acc == ACC_DATA);
    assign stat_commit = bus.RXE && (acc == ACC_STAT);
    assign tx_pop      = data_commit && hold_valid;

    assign status_byte = pack_status('{ovf:      RX_OVF,
                                       rx_full:  rx_full,
                                       rx_empty: RX_EMPTY,
                                       tx_full:  TX_FULL,
                                       tx_empty: tx_empty});

    // The TX head is only copied at the TXE rise; it is popped when the host
    // commits the byte, so a prefetched-but-abandoned byte stays queued.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            txe_q      <= 1'b0;
            hold       <= FILL;
            hold_valid <= 1'b0;
            RX_OVF     <= 1'b0;
        end else begin
            txe_q <= bus.TXE;

            if (!bus.SEL) begin
                hold_valid <= 1'b0;
            end else if (txe_rise && acc == ACC_DATA) begin
                hold       <= tx_empty ? FILL : tx_head;
                hold_valid <= !tx_empty;
            end else if (txe_rise && acc == ACC_STAT) begin
                hold       <= status_byte;
                hold_valid <= 1'b0;
            end else if (data_commit) begin
                hold_valid <= 1'b0;
            end

            if (data_commit && rx_full)
                RX_OVF <= 1'b1;
            else if (stat_commit && bus.RXD[OVF_CLR_BIT])
                RX_OVF <= 1'b0;
        end
    end

    assign TXD = (bus.TXE && acc != ACC_NONE) ? hold : 8'bz;

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (TX_WR),
        .wr_data (TX_DATA),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .full    (TX_FULL),
        .empty   (tx_empty),
        .count   (TX_COUNT)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (data_commit),
        .wr_data (bus.RXD),
        .pop     (RX_RD),
        .rd_data (RX_DATA),
        .full    (rx_full),
        .empty   (RX_EMPTY),
        .count   (RX_COUNT)
    );

endmodule

// File: tb/tb_spi_fifo_port.sv
// Scoreboard bench for spi_fifo_port: emulates the gate's TXE/RXE byte timing
// and tracks both FIFOs plus the overflow flag in queue-based models.
module tb_spi_fifo_port;
    import spi_bus_pkg::*;

    localparam int         DL     = 4;
    localparam int         DEPTH  = 16;
    localparam logic [7:0] A_DATA = 8'h20;
    localparam logic [7:0] A_STAT = 8'h21;
    localparam logic [7:0] FILLV  = 8'hFF;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          TX_WR = 1'b0;
    logic [7:0]    TX_DATA = '0;
    logic          RX_RD = 1'b0;
    logic          TX_FULL, RX_EMPTY, RX_OVF;
    logic [DL:0]   TX_COUNT, RX_COUNT;
    logic [7:0]    RX_DATA;
    wire  [7:0]    txd;

    spi_fifo_port_if bus();

    spi_fifo_port #(.DEPTH_LOG2(DL), .FILL(FILLV)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ADDRESS      (A_DATA),
        .STAT_ADDRESS (A_STAT),
        .bus          (bus),
        .TXD          (txd),
        .TX_WR        (TX_WR),
        .TX_DATA      (TX_DATA),
        .TX_FULL      (TX_FULL),
        .TX_COUNT     (TX_COUNT),
        .RX_RD        (RX_RD),
        .RX_DATA      (RX_DATA),
        .RX_EMPTY     (RX_EMPTY),
        .RX_COUNT     (RX_COUNT),
        .RX_OVF       (RX_OVF)
    );

    always #5 CLK = ~CLK;

    logic [7:0] tx_m[$];
    logic [7:0] rx_m[$];
    logic [7:0] sb[$];
    bit         ovf_m;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] status_m();
        logic [7:0] s;
        s              = '0;
        s[ST_TX_EMPTY] = (tx_m.size() == 0);
        s[ST_TX_FULL]  = (tx_m.size() == DEPTH);
        s[ST_RX_EMPTY] = (rx_m.size() == 0);
        s[ST_RX_FULL]  = (rx_m.size() == DEPTH);
        s[ST_RX_OVF]   = ovf_m;
        return s;
    endfunction

    task automatic chk_flags(input string tag);
        @(negedge CLK);
        chk({tag, ".tx_count"}, 32'(TX_COUNT), 32'(tx_m.size()));
        chk({tag, ".rx_count"}, 32'(RX_COUNT), 32'(rx_m.size()));
        chk({tag, ".tx_full"},  32'(TX_FULL),  32'(tx_m.size() == DEPTH));
        chk({tag, ".rx_empty"}, 32'(RX_EMPTY), 32'(rx_m.size() == 0));
        chk({tag, ".rx_ovf"},   32'(RX_OVF),   32'(ovf_m));
        if (rx_m.size() != 0)
            chk({tag, ".rx_data"}, 32'(RX_DATA), 32'(rx_m[0]));
    endtask

    task automatic clear_model();
        tx_m.delete();
        rx_m.delete();
        sb.delete();
        ovf_m = 1'b0;
    endtask

    task automatic idle_bus();
        bus.SEL = 1'b0;
        bus.TXE = 1'b0;
        bus.RXE = 1'b0;
        bus.RXD = '0;
        bus.ADDR = '0;
        TX_WR = 1'b0;
        RX_RD = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(posedge CLK); #1;
        RST = 1'b1;
        idle_bus();
        clear_model();
        chk_flags(tag);
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic fabric_push(input logic [7:0] d);
        @(posedge CLK); #1;
        TX_WR = 1'b1;
        TX_DATA = d;
        @(posedge CLK); #1;
        TX_WR = 1'b0;
        if (tx_m.size() < DEPTH)
            tx_m.push_back(d);
    endtask

    // One gate byte: TXE rise, sample TXD on the second TXE cycle, then
    // (if commit) an RXE strobe carrying the host byte.
    task automatic host_byte(input logic [7:0] a, input logic [7:0] wd,
                             input bit commit, input bit rd);
        logic [7:0] got;
        bit         hv;
        bit         full0;
        bit         emp0;
        hv = (a == A_DATA) && (tx_m.size() != 0);
        sb.push_back(a == A_DATA ? (hv ? tx_m[0] : FILLV) : status_m());
        @(posedge CLK); #1;
        bus.TXE = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        got = txd;
        chk(a == A_DATA ? "txd_data" : "txd_stat", 32'(got), 32'(sb.pop_front()));
        @(posedge CLK); #1;
        if (commit) begin
            bus.RXD = wd;
            bus.RXE = 1'b1;
            RX_RD   = rd;
            @(posedge CLK); #1;
            bus.RXE = 1'b0;
            RX_RD   = 1'b0;
            full0 = (rx_m.size() == DEPTH);
            emp0  = (rx_m.size() == 0);
            if (rd && !emp0)
                void'(rx_m.pop_front());
            if (a == A_DATA) begin
                if (hv)
                    void'(tx_m.pop_front());
                if (!full0)
                    rx_m.push_back(wd);
                else
                    ovf_m = 1'b1;
            end else if (wd[7]) begin
                ovf_m = 1'b0;
            end
        end
        bus.TXE = 1'b0;
    endtask

    task automatic host_txn(input string tag, input logic [7:0] a, input int n,
                            input logic [7:0] base, input bit rd);
        @(posedge CLK); #1;
        bus.SEL  = 1'b1;
        bus.ADDR = a;
        for (int i = 0; i < n; i++)
            host_byte(a, base + 8'(i), 1'b1, rd);
        host_byte(a, 8'h00, 1'b0, 1'b0);     // gate prefetch, never committed
        @(posedge CLK); #1;
        bus.SEL = 1'b0;
        chk_flags(tag);
    endtask

    initial begin
        idle_bus();
        clear_model();
        do_reset("reset");

        // 1: burst read of queued bytes, then a leftover byte carried across nCS
        fabric_push(8'h11);
        fabric_push(8'h22);
        fabric_push(8'h33);
        host_txn("t1a", A_DATA, 3, 8'hA0, 1'b0);
        fabric_push(8'h44);
        fabric_push(8'h55);
        fabric_push(8'h66);
        fabric_push(8'h77);
        host_txn("t1b", A_DATA, 3, 8'hB0, 1'b0);
        host_txn("t1c", A_DATA, 1, 8'hC0, 1'b0);

        // 2: reads from an empty TX FIFO
        do_reset("t2.reset");
        host_txn("t2", A_DATA, 2, 8'h50, 1'b0);

        // 3: RX overflow, status read, write-1-to-clear
        do_reset("t3.reset");
        host_txn("t3.fill", A_DATA, 17, 8'h00, 1'b0);
        host_txn("t3.stat", A_STAT, 1, 8'h00, 1'b0);
        host_txn("t3.clr",  A_STAT, 1, 8'h80, 1'b0);

        // 4: fabric pop and host push on a full RX in the same cycle
        host_txn("t4", A_DATA, 1, 8'hEE, 1'b1);

        // 5: deselect mid-byte leaves both FIFOs alone
        fabric_push(8'h5A);
        @(posedge CLK); #1;
        bus.SEL  = 1'b1;
        bus.ADDR = A_DATA;
        host_byte(A_DATA, 8'h99, 1'b0, 1'b0);
        @(posedge CLK); #1;
        bus.SEL = 1'b0;
        chk_flags("t5");
        host_txn("t5.next", A_DATA, 0, 8'h00, 1'b0);

        // 6: async reset in the middle of a byte with both FIFOs occupied
        do_reset("t6.reset");
        host_txn("t6.rx", A_DATA, 3, 8'h30, 1'b0);
        for (int i = 0; i < 5; i++)
            fabric_push(8'h60 + 8'(i));
        chk_flags("t6.pre");
        for (int i = 0; i < 12; i++)
            fabric_push(8'h70 + 8'(i));
        chk_flags("t6.txfull");
        @(posedge CLK); #1;
        bus.SEL  = 1'b1;
        bus.ADDR = A_DATA;
        @(posedge CLK); #1;
        bus.TXE = 1'b1;
        bus.RXD = 8'h77;
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        chk("t6.async.tx_count", 32'(TX_COUNT), 32'd0);
        chk("t6.async.rx_count", 32'(RX_COUNT), 32'd0);
        chk("t6.async.rx_empty", 32'(RX_EMPTY), 32'd1);
        chk("t6.async.tx_full",  32'(TX_FULL),  32'd0);
        idle_bus();
        clear_model();
        @(posedge CLK); #1;
        RST = 1'b0;
        host_txn("t6.after", A_DATA, 1, 8'h01, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
